seq_det_param: RTL and testbench
================================

// Module: seq_det_param
// PURPOSE
//  Parametrised serial pattern detector. Runtime-loadable pattern of PAT_LEN bits, valid-qualified input,
//  selectable overlapping/non-overlapping mode, Mealy match pulse. Sits on a serial bit stream.
//  Generalises the fixed 3-bit detectors to any length and mode, with an optional match counter.
// PARAMETERS
//  PAT_LEN  3        pattern length in bits, legal range 2..32
//  RST_PAT  3'b101   pattern in effect after reset, PAT_LEN bits wide
//  CNT_W    8        match counter width (used only with SEQ_DET_CNT_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        in_bit is valid this cycle
//  in_bit     in   1        serial data bit
//  overlap    in   1        1 = overlapping detection, 0 = non-overlapping
//  pat_load   in   1        load pat_in as the new pattern
//  pat_in     in   PAT_LEN  new pattern; bit [PAT_LEN-1] is the first bit received, bit [0] the last
//  pattern    out  PAT_LEN  registered active pattern
//  armed      out  1        history holds at least PAT_LEN-1 valid bits
//  match      out  1        Mealy match pulse, combinational from the current inputs
//  cnt_clr    in   1        clear the match counter (SEQ_DET_CNT_EN only)
//  match_cnt  out  CNT_W    saturating match count (SEQ_DET_CNT_EN only)
// BEHAVIOUR
//  - Reset (async) values: pattern=RST_PAT, hist=0, fill=0, armed=0, match=0, match_cnt=0.
//  - State:
//    - hist: PAT_LEN-1 bit shift register; the newest bit enters at [0].
//    - fill: count of valid bits, saturating at PAT_LEN-1.
//    - armed = (fill == PAT_LEN-1).
//  - Match condition: match = in_valid & ~pat_load & armed & ({hist, in_bit} == pattern).
//    - Latency 0: match asserts in the same cycle as the last pattern bit.
//  - Cycle with in_valid=1 and no load: hist <= {hist[PAT_LEN-3:0], in_bit}.
//    - fill increments, saturating.
//    - If match=1 and overlap=0: fill <= 0. hist still shifts, but its contents are ignored until re-armed.
//    - If match=1 and overlap=1: fill is unchanged, so the suffix can seed the next match.
//  - Cycle with in_valid=0: hist and fill hold; match=0. Gaps of any length are transparent.
//  - pat_load=1: pattern <= pat_in, hist <= 0, fill <= 0, match=0.
//    - Load has priority over in_valid in the same cycle; that in_bit is discarded.
//  - overlap is sampled each cycle. A change applies to the next match; history is not flushed.
//  - PAT_LEN=2: hist is 1 bit wide and the shift degenerates to hist <= in_bit.
//  - Async reset mid-stream: all state clears immediately; match drops in the same cycle.
// CONFIGURATION
//  - SEQ_DET_CNT_EN defined:
//    - match_cnt increments on every cycle with match=1 and saturates at all-ones.
//    - cnt_clr=1 forces match_cnt <= 0. cnt_clr wins over a simultaneous match.
//  - SEQ_DET_CNT_EN undefined:
//    - match_cnt is tied to 0 and cnt_clr is ignored.
//    - No counter flops are generated.
// STRUCTURE
//  - seq_det_pkg holds:
//    - default constants PAT_LEN_DEF=3, RST_PAT_DEF=3'b101, CNT_W_DEF=8
//    - function fill_w(n) = $clog2(n) for the fill counter width
//  - Sub-module seq_det_hist: hist shift register plus fill counter, with shift, flush and armed ports.
//    - seq_det_param adds the compare, mode logic, pattern register and counter.
// TESTING
//  1. RST_PAT=101, overlap=1, stream 1,0,1,0,1 (valid every cycle)
//     -> match on bit 3 and bit 5; count=2.
//  2. Same stream, overlap=0 -> match on bit 3 only; armed=0 right after bit 3; count=1.
//  3. Stream 1,-,0,-,-,1 (- = in_valid low) -> single match on the third valid bit; match=0 in every gap cycle.
//  4. Load pat_in=011 after bits 1,0; then send 0,1,1 -> armed=0 right after the load;
//     match on the final 1; pattern reads 011.
//  5. CNT_W=2, overlap=1, stream of 1,0 repeated for 10 bits -> match_cnt saturates at 3.
//     Then cnt_clr together with a match -> match_cnt=0.
//  6. Assert rst asynchronously in the cycle the last bit of 101 is present
//     -> match=0 immediately; fill=0; pattern=101 after release.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int         PAT_LEN_DEF = 3;
    localparam logic [2:0] RST_PAT_DEF = 3'b101;
    localparam int         CNT_W_DEF   = 8;

    // Fill counter only needs to reach n-1.
    function automatic int fill_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register plus saturating fill counter for seq_det_param.
// flush clears history and fill; restart clears only fill while history keeps shifting.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = PAT_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               in_bit,
    input  logic               flush,
    input  logic               restart,
    output logic [PAT_LEN-2:0] hist,
    output logic               armed
);

    localparam int            FW       = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

    logic [FW-1:0]      fill;
    logic [PAT_LEN-2:0] hist_nx;

    generate
        if (PAT_LEN == 2) begin : g_one_bit
            assign hist_nx = in_bit;
        end else begin : g_multi_bit
            assign hist_nx = {hist[PAT_LEN-3:0], in_bit};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (flush) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_nx;
            if (restart)
                fill <= '0;
            else if (fill != FILL_MAX)
                fill <= fill + 1'b1;
        end
    end

    assign armed = (fill == FILL_MAX);

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern and Mealy match pulse.
// Optional saturating match counter is built only when SEQ_DET_CNT_EN is defined.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(RST_PAT_DEF),
    parameter int                 CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic [PAT_LEN-1:0] pattern,
    output logic               armed,
    output logic               match,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [PAT_LEN-2:0] hist;
    logic               shift;

    assign shift = in_valid & ~pat_load;
    assign match = shift & armed & ({hist, in_bit} == pattern);

    seq_det_hist #(
        .PAT_LEN (PAT_LEN)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .in_bit  (in_bit),
        .flush   (pat_load),
        .restart (match & ~overlap),
        .hist    (hist),
        .armed   (armed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pattern <= RST_PAT;
        else if (pat_load)
            pattern <= pat_in;
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear wins over a match in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (cnt_clr)
            cnt_q <= '0;
        else if (match && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param (PAT_LEN=3, RST_PAT=101, CNT_W=2).
// Counter expectations follow SEQ_DET_CNT_EN: real counts when defined, zero otherwise.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_bit, overlap, pat_load, cnt_clr;
    logic [2:0] pat_in;
    logic [2:0] pattern;
    logic       armed, match;
    logic [1:0] match_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    seq_det_param #(
        .PAT_LEN (3),
        .RST_PAT (3'b101),
        .CNT_W   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .pattern   (pattern),
        .armed     (armed),
        .match     (match),
        .cnt_clr   (cnt_clr),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int v);
`ifdef SEQ_DET_CNT_EN
        return v;
`else
        return (v > 0) ? 0 : 0;
`endif
    endfunction

    // Entered at posedge+1: drive inputs, check the Mealy output mid-cycle, advance to next posedge+1.
    task automatic cyc(input logic v, input logic b, input logic ld, input logic [2:0] p,
                       input logic clr, input logic exp_m, input string tag);
        in_valid = v;
        in_bit   = b;
        pat_load = ld;
        pat_in   = p;
        cnt_clr  = clr;
        #2;
        chk(tag, 32'(match), 32'(exp_m));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, "idle");
    endtask

    task automatic flush_clr(input logic [2:0] p);
        cyc(1'b0, 1'b0, 1'b1, p, 1'b1, 1'b0, "load");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = 3'b000; cnt_clr = 1'b0;
        #12;
        chk("rst_pattern", 32'(pattern), 32'h5);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: overlapping 1,0,1,0,1
        overlap = 1'b1;
        cyc(1, 1, 0, 0, 0, 0, "t1_b1");
        cyc(1, 0, 0, 0, 0, 0, "t1_b2");
        chk("t1_armed", 32'(armed), 1);
        cyc(1, 1, 0, 0, 0, 1, "t1_b3");
        chk("t1_armed_keep", 32'(armed), 1);
        cyc(1, 0, 0, 0, 0, 0, "t1_b4");
        cyc(1, 1, 0, 0, 0, 1, "t1_b5");
        chk("t1_cnt", 32'(match_cnt), ecnt(2));

        // 2: non-overlapping, same stream
        flush_clr(3'b101);
        overlap = 1'b0;
        cyc(1, 1, 0, 0, 0, 0, "t2_b1");
        cyc(1, 0, 0, 0, 0, 0, "t2_b2");
        cyc(1, 1, 0, 0, 0, 1, "t2_b3");
        chk("t2_armed_after", 32'(armed), 0);
        cyc(1, 0, 0, 0, 0, 0, "t2_b4");
        cyc(1, 1, 0, 0, 0, 0, "t2_b5");
        chk("t2_cnt", 32'(match_cnt), ecnt(1));

        // 3: gaps are transparent; gap with in_bit=1 while armed must not match
        flush_clr(3'b101);
        overlap = 1'b1;
        cyc(1, 1, 0, 0, 0, 0, "t3_b1");
        cyc(0, 1, 0, 0, 0, 0, "t3_gap1");
        cyc(1, 0, 0, 0, 0, 0, "t3_b2");
        cyc(0, 1, 0, 0, 0, 0, "t3_gap2");
        cyc(0, 0, 0, 0, 0, 0, "t3_gap3");
        cyc(1, 1, 0, 0, 0, 1, "t3_b3");
        chk("t3_cnt", 32'(match_cnt), ecnt(1));

        // 4: load 011 after 1,0; load cycle carries a bit that would match old pattern
        flush_clr(3'b101);
        cyc(1, 1, 0, 0, 0, 0, "t4_b1");
        cyc(1, 0, 0, 0, 0, 0, "t4_b2");
        cyc(1, 1, 1, 3'b011, 0, 0, "t4_load");
        chk("t4_armed_load", 32'(armed), 0);
        chk("t4_pattern", 32'(pattern), 32'h3);
        cyc(1, 0, 0, 0, 0, 0, "t4_b3");
        cyc(1, 1, 0, 0, 0, 0, "t4_b4");
        cyc(1, 1, 0, 0, 0, 1, "t4_b5");
        chk("t4_cnt", 32'(match_cnt), ecnt(1));

        // 5: saturation at 3, then clear beats a simultaneous match
        flush_clr(3'b101);
        overlap = 1'b1;
        for (int i = 0; i < 10; i++)
            cyc(1, ((i % 2) == 0), 0, 0, 0, (i >= 2) && ((i % 2) == 0), "t5_bit");
        chk("t5_sat", 32'(match_cnt), ecnt(3));
        cyc(1, 1, 0, 0, 1, 1, "t5_clr_match");
        chk("t5_clr", 32'(match_cnt), 0);

        // 6: async reset while the last bit of a match is present
        flush_clr(3'b110);
        cyc(1, 1, 0, 0, 0, 0, "t6_b1");
        cyc(1, 1, 0, 0, 0, 0, "t6_b2");
        in_valid = 1'b1;
        in_bit   = 1'b0;
        #2;
        chk("t6_pre_match", 32'(match), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_match", 32'(match), 0);
        chk("t6_rst_armed", 32'(armed), 0);
        chk("t6_rst_pattern", 32'(pattern), 32'h5);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_pattern_rel", 32'(pattern), 32'h5);
        chk("t6_armed_rel", 32'(armed), 0);
        cyc(1, 0, 0, 0, 0, 0, "t6_r1");
        cyc(1, 1, 0, 0, 0, 0, "t6_r2");
        chk("t6_armed_r2", 32'(armed), 1);
        cyc(1, 0, 0, 0, 0, 0, "t6_r3");
        cyc(1, 1, 0, 0, 0, 1, "t6_r4");
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
